// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM-state definitions for the logic-op arbiter and its gate unit.
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_NOTB = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational WIDTH-bit bitwise gate unit; the reserved opcode yields zero and flags err.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_NOTB: y = ~b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit between NREQ requesters, one result in flight.
// Optional per-requester grant counters are built when LOGIC_ARB_STATS_EN is defined.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef LOGIC_ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [NREQ*16-1:0]    grant_cnt,
`endif
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*3-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err
);

    state_t             state_reg;
    logic [IDW-1:0]     rr_ptr_reg;
    logic               rsp_valid_reg;
    logic [WIDTH-1:0]   rsp_data_reg;
    logic [IDW-1:0]     rsp_id_reg;
    logic               rsp_err_reg;

    logic               found;
    logic [IDW-1:0]     winner;
    logic [IDW:0]       scan_sum;
    logic [IDW:0]       rr_sum;
    logic [IDW-1:0]     rr_ptr_next;
    logic               grant_en;

    logic [2:0]         op_arr [NREQ];
    logic [WIDTH-1:0]   a_arr  [NREQ];
    logic [WIDTH-1:0]   b_arr  [NREQ];
    logic [WIDTH-1:0]   unit_y;
    logic               unit_err;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op[gi*3 +: 3];
        assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
    end

    // Scan from rr_ptr upward with explicit wrap so non-power-of-two NREQ works.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NREQ))
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            if (!found && req_valid[scan_sum[IDW-1:0]]) begin
                found  = 1'b1;
                winner = scan_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        rr_sum = {1'b0, winner} + (IDW+1)'(1);
        if (rr_sum >= (IDW+1)'(NREQ))
            rr_sum = rr_sum - (IDW+1)'(NREQ);
        rr_ptr_next = rr_sum[IDW-1:0];
    end

    assign grant_en = rst_n && (state_reg == ST_IDLE) && found;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = grant_en && (winner == IDW'(gi));
    end

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .op  (op_arr[winner]),
        .a   (a_arr[winner]),
        .b   (b_arr[winner]),
        .y   (unit_y),
        .err (unit_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (found) begin
                        rsp_data_reg  <= unit_y;
                        rsp_id_reg    <= winner;
                        rsp_err_reg   <= unit_err;
                        rr_ptr_reg    <= rr_ptr_next;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_err   = rsp_err_reg;

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] cnt_reg [NREQ];

    // Saturating grant counters; a clear in the same cycle as a grant leaves zero.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt_reg[gi] <= '0;
            else if (stats_clr)
                cnt_reg[gi] <= '0;
            else if (req_ready[gi] && (cnt_reg[gi] != 16'hFFFF))
                cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
        assign grant_cnt[gi*16 +: 16] = cnt_reg[gi];
    end
`endif

endmodule
